// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - memory request/ready handshake between controller and memory
interface multicycle_controller_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_src;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_src,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_src,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - control FSM for the multicycle RV32I core
module multicycle_controller (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              op,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  input  logic                    alu_zero,
  input  logic                    alu_lt,
  input  logic                    alu_ltu,
  multicycle_controller_if.master mem,
  output logic                    ir_we,
  output logic                    pc_we,
  output logic [1:0]              pc_src,
  output logic                    rf_we,
  output logic [1:0]              rf_wsel,
  output logic                    alu_a_sel,
  output logic [1:0]              alu_b_sel,
  output logic [3:0]              alu_ctrl,
  output logic                    illegal,
  output logic [2:0]              state
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  state_t cur, nxt;

  always_ff @(posedge clk) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  function automatic logic [3:0] arith_ctrl(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_ctrl = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_ctrl = ALU_SLL;
      3'b010:  arith_ctrl = ALU_SLT;
      3'b011:  arith_ctrl = ALU_SLTU;
      3'b100:  arith_ctrl = ALU_XOR;
      3'b101:  arith_ctrl = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_ctrl = ALU_OR;
      default: arith_ctrl = ALU_AND;
    endcase
  endfunction

  logic op_legal, br_legal, br_taken;

  always_comb begin
    op_legal = (funct7 == 7'b0000000) ||
               ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    br_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
    case (funct3)
      3'b000:  br_taken = alu_zero;
      3'b001:  br_taken = !alu_zero;
      3'b100:  br_taken = alu_lt;
      3'b101:  br_taken = !alu_lt;
      3'b110:  br_taken = alu_ltu;
      3'b111:  br_taken = !alu_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  // ALU setup per opcode; EXECUTE, MEM and WRITEBACK all present the same values.
  logic       ex_a_sel;
  logic [1:0] ex_b_sel;
  logic [3:0] ex_ctrl;

  always_comb begin
    ex_a_sel = 1'b0;
    ex_b_sel = 2'd0;
    ex_ctrl  = ALU_ADD;
    case (op)
      OPC_OP:     ex_ctrl = arith_ctrl(funct3, funct7[5]);
      OPC_OP_IMM: begin
        ex_b_sel = 2'd1;
        ex_ctrl  = arith_ctrl(funct3, (funct3 == 3'b101) && funct7[5]);
      end
      OPC_LOAD,
      OPC_JALR:   ex_b_sel = 2'd1;
      OPC_STORE:  ex_b_sel = 2'd2;
      OPC_AUIPC:  begin
        ex_a_sel = 1'b1;
        ex_b_sel = 2'd3;
      end
      OPC_BRANCH: ex_ctrl = ALU_SUB;
      default:    ;
    endcase
  end

  logic req, we, addr_src;

  always_comb begin
    nxt       = cur;
    req       = 1'b0;
    we        = 1'b0;
    addr_src  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    rf_we     = 1'b0;
    rf_wsel   = 2'd0;
    alu_a_sel = 1'b0;
    alu_b_sel = 2'd0;
    alu_ctrl  = ALU_ADD;
    illegal   = 1'b0;
    state     = cur;

    case (cur)
      S_FETCH: begin
        req = 1'b1;
        if (mem.mem_ready) begin
          ir_we = 1'b1;
          nxt   = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
          OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: nxt = S_EXECUTE;
          OPC_FENCE: begin
            pc_we = 1'b1;
            nxt   = S_FETCH;
          end
          default: nxt = S_TRAP;
        endcase
      end
      S_EXECUTE: begin
        alu_a_sel = ex_a_sel;
        alu_b_sel = ex_b_sel;
        alu_ctrl  = ex_ctrl;
        if (op == OPC_BRANCH) begin
          if (br_legal) begin
            pc_we  = 1'b1;
            pc_src = br_taken ? 2'd1 : 2'd0;
            nxt    = S_FETCH;
          end else begin
            nxt = S_TRAP;
          end
        end else if ((op == OPC_OP) && !op_legal) begin
          nxt = S_TRAP;
        end else if ((op == OPC_LOAD) || (op == OPC_STORE)) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WRITEBACK;
        end
      end
      S_MEM: begin
        alu_a_sel = ex_a_sel;
        alu_b_sel = ex_b_sel;
        alu_ctrl  = ex_ctrl;
        req       = 1'b1;
        addr_src  = 1'b1;
        we        = (op == OPC_STORE);
        if (mem.mem_ready) begin
          if (op == OPC_STORE) begin
            pc_we = 1'b1;
            nxt   = S_FETCH;
          end else begin
            nxt = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        alu_a_sel = ex_a_sel;
        alu_b_sel = ex_b_sel;
        alu_ctrl  = ex_ctrl;
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        nxt       = S_FETCH;
        case (op)
          OPC_LOAD:  rf_wsel = 2'd1;
          OPC_JAL:   begin rf_wsel = 2'd2; pc_src = 2'd2; end
          OPC_JALR:  begin rf_wsel = 2'd2; pc_src = 2'd3; end
          OPC_LUI:   rf_wsel = 2'd3;
          default:   rf_wsel = 2'd0;
        endcase
      end
      S_TRAP: illegal = 1'b1;
      default: nxt = S_FETCH;
    endcase

    // Reset blanks every output so nothing fires in the cycle reset is sampled.
    if (reset) begin
      req       = 1'b0;
      we        = 1'b0;
      addr_src  = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 2'd0;
      rf_we     = 1'b0;
      rf_wsel   = 2'd0;
      alu_a_sel = 1'b0;
      alu_b_sel = 2'd0;
      alu_ctrl  = ALU_ADD;
      illegal   = 1'b0;
      state     = 3'd0;
    end
  end

  assign mem.mem_req      = req;
  assign mem.mem_we       = we;
  assign mem.mem_addr_src = addr_src;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RV32I core. It sequences fetch, decode, execute, memory and writeback over the shared ALU, register file and single memory port. It consumes the decoded `op`/`funct3`/`funct7` fields and the ALU compare flags, and drives every enable and mux select in the datapath. It owns the single memory request/ready handshake and traps permanently on unsupported encodings.

## Interface
- No parameters.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 7: opcode from decoder, taken from the instruction register.
- `funct3` in 3: from decoder.
- `funct7` in 7: from decoder.
- `alu_zero` in 1: ALU result == 0.
- `alu_lt` in 1: signed rs1 < rs2.
- `alu_ltu` in 1: unsigned rs1 < rs2.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request.
- `mem_we` out 1: store when high, read when low.
- `mem_addr_src` out 1: memory address select. 0 = PC, 1 = ALU result.
- `ir_we` out 1: instruction register load.
- `pc_we` out 1: PC load.
- `pc_src` out 2: PC source. 0 = PC+4, 1 = PC+imm_b_sext, 2 = PC+imm_j_sext, 3 = ALU result & ~1.
- `rf_we` out 1: register-file write.
- `rf_wsel` out 2: write-data select. 0 = ALU, 1 = memory data, 2 = PC+4, 3 = {imm_u, 12'b0}.
- `alu_a_sel` out 1: ALU A select. 0 = rs1, 1 = PC.
- `alu_b_sel` out 2: ALU B select. 0 = rs2, 1 = imm_i_sext, 2 = S-immediate, 3 = {imm_u, 12'b0}.
- `alu_ctrl` out 4: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
- `illegal` out 1: sticky trap flag.
- `state` out 3: current state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5.
- Register: only the 3-bit state.
- Outputs: combinational from state, op, funct3, funct7 and flags. `op`/`funct*` are stable from DECODE onward.
- Defaults: every enable and select not listed for a state is 0.
- **FETCH:** mem_req=1, mem_addr_src=0, mem_we=0.
  - When mem_ready=1: ir_we=1, next state DECODE.
  - Otherwise stay in FETCH.
- **DECODE:** one cycle, no enables asserted.
  - Supported ops: OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC go to EXECUTE.
  - FENCE (0001111) goes to FETCH with pc_we=1, pc_src=0 (no-op).
  - Any other opcode, including SYSTEM, goes to TRAP.
- **EXECUTE, by op:**
  - OP: alu_b_sel=0. alu_ctrl from funct3, with funct7=0100000 selecting SUB (funct3 000) or SRA (funct3 101). Any funct7 other than 0000000/0100000, or 0100000 with another funct3, goes to TRAP.
  - OP-IMM: alu_b_sel=1. funct7[5] is honored only for funct3=101 (SRAI).
  - LOAD/JALR: alu_b_sel=1, ADD. STORE: alu_b_sel=2, ADD.
  - AUIPC: alu_a_sel=1, alu_b_sel=3, ADD.
  - BRANCH: alu_b_sel=0, SUB, then pc_we=1.
    - Taken condition by funct3: 000 alu_zero, 001 !alu_zero, 100 alu_lt, 101 !alu_lt, 110 alu_ltu, 111 !alu_ltu.
    - pc_src=1 if taken, else 0. Next state FETCH.
    - funct3 010/011 go to TRAP.
  - LOAD/STORE go to MEM. All other ops go to WRITEBACK.
- **MEM:** mem_req=1, mem_addr_src=1, mem_we=1 for STORE. ALU inputs and control held as in EXECUTE.
  - Stay in MEM until mem_ready=1.
  - Then LOAD goes to WRITEBACK.
  - STORE asserts pc_we=1, pc_src=0 and goes to FETCH.
- **WRITEBACK:** rf_we=1, pc_we=1, next state FETCH. ALU inputs and control held as in EXECUTE.
  - rf_wsel: OP/OP-IMM/AUIPC 0, LOAD 1, JAL/JALR 2, LUI 3.
  - pc_src: JAL 2, JALR 3, others 0.
  - x0 suppression is the register file's job.
- **TRAP:** illegal=1, all enables 0. State is held until reset.

## Timing
- Reset:
  - While reset=1, all outputs are forced to 0, including illegal.
  - Reset-edge state = FETCH.
  - The first cycle after reset falls has mem_req=1.
- Reset mid-operation (including MEM with mem_req high): mem_req drops in the cycle reset is sampled. No rf_we or pc_we fires in that cycle.
- Memory handshake:
  - mem_req, mem_we and the address selects are held stable until the cycle mem_ready=1.
  - mem_ready is ignored when mem_req=0.
  - With zero wait states, completion occurs in the same cycle as the request.
- Latency with zero-wait memory: BRANCH 3 cycles; OP/OP-IMM/LUI/AUIPC/JAL/JALR 4; STORE 4; LOAD 5.
- Each memory wait cycle adds exactly one cycle.
- pc_we asserts exactly once per retired instruction, in its last cycle. ir_we asserts exactly once per instruction.

## Test plan
- Reset, then ADD x3,x1,x2 (0x002081B3) with mem_ready always 1:
  - states 0,1,2,4,0
  - WRITEBACK shows rf_we=1, rf_wsel=0, pc_we=1, pc_src=0
  - EXECUTE shows alu_ctrl=0
- LW (0x0000A183) with mem_ready low for 3 MEM cycles:
  - mem_req=1, mem_addr_src=1 held 4 cycles
  - then WRITEBACK with rf_wsel=1; 8 cycles total
- BNE (funct3 001):
  - alu_zero=0 gives pc_src=1, pc_we=1 in EXECUTE and a return to FETCH after 3 cycles.
  - Repeat with alu_zero=1: pc_src=0.
  - Repeat with BLTU, alu_ltu=1: pc_src=1.
- JAL then JALR:
  - JAL WRITEBACK: rf_wsel=2, pc_src=2.
  - JALR WRITEBACK: rf_wsel=2, pc_src=3.
  - SRAI (funct7=0100000, funct3=101): alu_ctrl=7.
- Illegal encodings:
  - op=1110011 gives TRAP after DECODE: illegal=1 with no enables for 10 cycles. Reset clears it.
  - OP with funct7=0000001 gives TRAP from EXECUTE.
  - BRANCH with funct3=010 gives TRAP from EXECUTE.
- Store with reset asserted in the MEM cycle: mem_req=0 and pc_we=0 that cycle, then FETCH with mem_req=1 after release.
